// File: rtl/detector_stream_arbiter_pkg.sv
// Shared types for the detector stream arbiter: FSM state encoding and the
// hit-counter width derivation.
package detector_stream_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Width able to hold the values 0..width (hit count and bit index).
    function automatic int calc_cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/detector_stream_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins outright; on a tie the
// requester that did not win last time is chosen.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    input  logic       en_i,
    output logic       winner_o,
    output logic       valid_o
);

    assign valid_o  = en_i & (|req_i);
    assign winner_o = (req_i == 2'b11) ? ~rr_last_i : req_i[1];

endmodule

// File: rtl/detector_stream_arbiter.sv
// Shares one serial sequence detector between two requesters: clears it,
// shifts the granted word in MSB-first and returns the number of hits.
//
// state | meaning
// IDLE  | waiting for a request; arbitration and word capture on the exit edge
// CLEAR | detector held in reset for one cycle; grant pulse visible
// SHIFT | one word bit per cycle onto det_w; det_z of the previous bit counted
// DRAIN | det_z of the final bit counted; result registered
// DONE  | done pulse with hit_count/done_id valid
module detector_stream_arbiter
    import detector_stream_arbiter_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = calc_cw(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [CW-1:0]    hit_count,
    output logic             det_reset_n,
    output logic             det_w,
    input  logic             det_z
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    hit_count_q, hit_count_d;
    logic             rr_last_q, rr_last_d;
    logic             done_id_q, done_id_d;
    logic             done_q, done_d;
    logic [1:0]       grant_q, grant_d;

    logic             arb_winner;
    logic             arb_valid;

    rr_arbiter2 u_rr_arbiter2 (
        .req_i     (req),
        .rr_last_i (rr_last_q),
        .en_i      (state_q == ST_IDLE),
        .winner_o  (arb_winner),
        .valid_o   (arb_valid)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            hit_count_q <= '0;
            rr_last_q   <= 1'b1;
            done_id_q   <= 1'b0;
            done_q      <= 1'b0;
            grant_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            hit_count_q <= hit_count_d;
            rr_last_q   <= rr_last_d;
            done_id_q   <= done_id_d;
            done_q      <= done_d;
            grant_q     <= grant_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        hit_count_d = hit_count_q;
        rr_last_d   = rr_last_q;
        done_id_d   = done_id_q;
        done_d      = 1'b0;
        grant_d     = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d   = ST_CLEAR;
                    shift_d   = arb_winner ? data1 : data0;
                    rr_last_d = arb_winner;
                    done_id_d = arb_winner;
                    grant_d   = arb_winner ? 2'b10 : 2'b01;
                    acc_d     = '0;
                    idx_d     = '0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                idx_d   = idx_q + CW'(1);
                // det_z lags det_w by one edge, so index 0 has nothing to count yet.
                if (idx_q != '0) begin
                    acc_d = acc_q + CW'(det_z);
                end
                if (idx_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                acc_d       = acc_q + CW'(det_z);
                hit_count_d = acc_q + CW'(det_z);
                done_d      = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant       = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign done_id     = done_id_q;
    assign hit_count   = hit_count_q;
    assign det_reset_n = reset_n & (state_q != ST_CLEAR);
    assign det_w       = (state_q == ST_SHIFT) ? shift_q[WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_detector_stream_arbiter.sv
// Bench for detector_stream_arbiter: detector model, transaction-timeline
// reference model with per-cycle compare, and directed scenarios.
module tb_detector_stream_arbiter;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clock;
    logic          reset_n;
    logic [1:0]    req;
    logic [W-1:0]  data0, data1;
    logic [1:0]    grant;
    logic          busy, done, done_id;
    logic [CW-1:0] hit_count;
    logic          det_reset_n, det_w, det_z;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit cmp_en   = 0;

    detector_stream_arbiter #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .data0       (data0),
        .data1       (data1),
        .grant       (grant),
        .busy        (busy),
        .done        (done),
        .done_id     (done_id),
        .hit_count   (hit_count),
        .det_reset_n (det_reset_n),
        .det_w       (det_w),
        .det_z       (det_z)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Detector: z=1 when the last four bits are 1111 or 1101.
    logic [3:0] dhist = 4'h0;
    always @(posedge clock) begin
        if (!det_reset_n) dhist <= 4'h0;
        else              dhist <= {dhist[2:0], det_w};
    end
    assign det_z = (dhist == 4'b1111) || (dhist == 4'b1101);

    function automatic int ref_hits(input logic [W-1:0] word);
        logic [3:0] h;
        int n;
        h = 4'h0;
        n = 0;
        for (int i = W - 1; i >= 0; i--) begin
            h = {h[2:0], word[i]};
            if (h == 4'b1111 || h == 4'b1101) n++;
        end
        return n;
    endfunction

    // Reference: m_phase counts cycles since the grant cycle (-1 = idle).
    int           m_phase   = -1;
    logic [W-1:0] m_word    = '0;
    logic         m_rr_last = 1'b1;
    logic         m_id      = 1'b0;
    int           m_hit     = 0;
    logic         m_win;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_phase   = -1;
            m_rr_last = 1'b1;
            m_id      = 1'b0;
            m_hit     = 0;
        end else if (m_phase < 0) begin
            if (req != 2'b00) begin
                m_win     = (req == 2'b11) ? !m_rr_last : req[1];
                m_word    = m_win ? data1 : data0;
                m_rr_last = m_win;
                m_id      = m_win;
                m_phase   = 0;
            end
        end else begin
            m_phase++;
            if (m_phase == W + 2) m_hit = ref_hits(m_word);
            if (m_phase == W + 3) m_phase = -1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            check("m_grant",   {30'd0, grant},
                  (m_phase == 0) ? (m_id ? 32'd2 : 32'd1) : 32'd0);
            check("m_busy",    {31'd0, busy},    (m_phase >= 0) ? 32'd1 : 32'd0);
            check("m_done",    {31'd0, done},    (m_phase == W + 2) ? 32'd1 : 32'd0);
            check("m_done_id", {31'd0, done_id}, {31'd0, m_id});
            check("m_hit",     32'(hit_count),   32'(m_hit));
            check("m_det_w",   {31'd0, det_w},
                  (m_phase >= 1 && m_phase <= W) ? {31'd0, m_word[W - m_phase]} : 32'd0);
            check("m_det_rst", {31'd0, det_reset_n},
                  (reset_n && m_phase != 0) ? 32'd1 : 32'd0);
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_grant(output int t, output logic [1:0] g);
        t = -1;
        g = 2'b00;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (grant != 2'b00) begin
                g = grant;
                t = cyc;
                break;
            end
        end
        if (t < 0) timeout("grant_wait");
    endtask

    task automatic wait_done(output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) timeout("done_wait");
    endtask

    task automatic txn(input logic [1:0] r, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic exp_id, input int exp_hits);
        int tg, td;
        logic [1:0] g;
        req   = r;
        data0 = d0;
        data1 = d1;
        wait_grant(tg, g);
        req = 2'b00;
        check("txn_grant", {30'd0, g}, exp_id ? 32'd2 : 32'd1);
        wait_done(td);
        check("txn_latency", td - tg, W + 2);
        check("txn_hits",    32'(hit_count), exp_hits);
        check("txn_done_id", {31'd0, done_id}, {31'd0, exp_id});
    endtask

    initial begin
        int tg, td, prev, n_extra, n_done;
        logic [1:0] g;
        logic [W-1:0] dw;
        reset_n = 1'b0;
        req     = 2'b00;
        data0   = '0;
        data1   = '0;

        // Scenario 1: reset held 3 cycles, then idle.
        tick();
        cmp_en = 1;
        check("rst_det_reset_n", {31'd0, det_reset_n}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("idle_grant", {30'd0, grant}, 0);
        check("idle_busy",  {31'd0, busy}, 0);
        check("idle_done",  {31'd0, done}, 0);
        check("idle_hit",   32'(hit_count), 0);
        check("idle_det_reset_n", {31'd0, det_reset_n}, 1);

        // Scenario 2: single request 0, det_w sequence and latency.
        req   = 2'b01;
        data0 = 8'b1101_1010;
        wait_grant(tg, g);
        req = 2'b00;
        check("s2_grant", {30'd0, g}, 1);
        dw = '0;
        for (int i = 0; i < W; i++) begin
            tick();
            dw[W-1-i] = det_w;
        end
        check("s2_det_w_seq", {24'd0, dw}, 32'hDA);
        wait_done(td);
        check("s2_latency", td - tg, 10);
        check("s2_hits",    32'(hit_count), 2);
        check("s2_done_id", {31'd0, done_id}, 0);

        // Scenario 3: requester 1 with three words.
        txn(2'b10, 8'h00, 8'b1111_1111, 1'b1, 5);
        txn(2'b10, 8'h00, 8'b1111_0000, 1'b1, 1);
        txn(2'b10, 8'h00, 8'h00,        1'b1, 0);

        // Scenario 4: continuous contention alternates grants.
        req   = 2'b11;
        data0 = 8'hDA;
        data1 = 8'hFF;
        prev  = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(tg, g);
            check("s4_grant", {30'd0, g}, (k % 2 == 1) ? 2 : 1);
            if (k > 0) check("s4_period", tg - prev, 12);
            prev = tg;
            if (k == 3) req = 2'b00;
            wait_done(td);
            check("s4_done_id", {31'd0, done_id}, k % 2);
            check("s4_hits", 32'(hit_count), (k % 2 == 1) ? 5 : 2);
        end

        // Scenario 5: reset during SHIFT index 4 aborts the transaction.
        req   = 2'b01;
        data0 = 8'hFF;
        wait_grant(tg, g);
        req = 2'b00;
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("s5_busy", {31'd0, busy}, 0);
        check("s5_hit",  32'(hit_count), 0);
        check("s5_done", {31'd0, done}, 0);
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) n_done++;
        end
        check("s5_no_done", n_done, 0);
        req   = 2'b11;
        data0 = 8'hDA;
        data1 = 8'h00;
        wait_grant(tg, g);
        req = 2'b00;
        check("s5_tie_after_reset", {30'd0, g}, 1);
        wait_done(td);
        check("s5_done_id", {31'd0, done_id}, 0);

        // Scenario 6: data and req changes while busy are ignored.
        req   = 2'b01;
        data0 = 8'b1111_0000;
        wait_grant(tg, g);
        n_extra = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (grant != 2'b00) n_extra++;
            data0 = 8'hFF ^ W'(i);
            req   = i[0] ? 2'b01 : 2'b00;
        end
        req = 2'b00;
        wait_done(td);
        check("s6_hits",        32'(hit_count), 1);
        check("s6_done_id",     {31'd0, done_id}, 0);
        check("s6_extra_grant", n_extra, 0);
        tick();
        tick();
        check("s6_idle_grant", {30'd0, grant}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
